// File: rtl/sub_multicycle.sv
// Multi-cycle subtractor: one CHUNK-bit slice per clock, LSB first.
// Produces diff, unsigned borrow and Y86 condition flags.
module sub_multicycle #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SW     = CHUNK + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("sub_multicycle: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_msb;
    logic             b_msb;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;

    logic [CHUNK-1:0] slice;
    logic             slice_bo;
    logic [WIDTH-1:0] next_res;
    logic             last;

    // Operand registers shift right so the active slice is always at bit 0.
    always_comb begin
        {slice_bo, slice} = {1'b0, a_q[CHUNK-1:0]}
                          - {1'b0, b_q[CHUNK-1:0]}
                          - SW'(brw);
        next_res = WIDTH'({slice, res} >> CHUNK);
        last     = (cnt == CW'(NCHUNK - 1));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            brw        <= 1'b0;
            cnt        <= '0;
            res        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zf         <= 1'b0;
            sf         <= 1'b0;
            of         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        brw   <= borrow_in;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q <= a_q >> CHUNK;
                    b_q <= b_q >> CHUNK;
                    brw <= slice_bo;
                    res <= next_res;
                    if (last) begin
                        diff       <= next_res;
                        borrow_out <= slice_bo;
                        zf         <= (next_res == '0);
                        sf         <= next_res[WIDTH-1];
                        of         <= (a_msb != b_msb)
                                    & (next_res[WIDTH-1] != a_msb);
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_multicycle.sv
// Bench for sub_multicycle: directed table, corner sequences,
// random ops vs. arithmetic model, and WIDTH=8 chunk sweep.
module tb_sub_multicycle;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bo;
    logic        zf;
    logic        sf;
    logic        of;

    logic [2:0]  s_in_valid;
    logic [2:0]  s_in_ready;
    logic [2:0]  s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_a;
    logic [7:0]  s_b;
    logic        s_bin;
    logic [7:0]  s_diff [3];
    logic [2:0]  s_bo;
    logic [2:0]  s_zf;
    logic [2:0]  s_sf;
    logic [2:0]  s_of;

    int nvec;
    int nerr;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bo;
        logic        zf;
        logic        sf;
        logic        of;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        zf;
        logic        sf;
        logic        of;
    } res_t;

    sub_multicycle #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(bo),
        .zf(zf), .sf(sf), .of(of)
    );

    sub_multicycle #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]),
        .a(s_a), .b(s_b), .borrow_in(s_bin),
        .out_valid(s_out_valid[0]), .out_ready(s_out_ready),
        .diff(s_diff[0]), .borrow_out(s_bo[0]),
        .zf(s_zf[0]), .sf(s_sf[0]), .of(s_of[0])
    );

    sub_multicycle #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]),
        .a(s_a), .b(s_b), .borrow_in(s_bin),
        .out_valid(s_out_valid[1]), .out_ready(s_out_ready),
        .diff(s_diff[1]), .borrow_out(s_bo[1]),
        .zf(s_zf[1]), .sf(s_sf[1]), .of(s_of[1])
    );

    sub_multicycle #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid[2]), .in_ready(s_in_ready[2]),
        .a(s_a), .b(s_b), .borrow_in(s_bin),
        .out_valid(s_out_valid[2]), .out_ready(s_out_ready),
        .diff(s_diff[2]), .borrow_out(s_bo[2]),
        .zf(s_zf[2]), .sf(s_sf[2]), .of(s_of[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, signed range check for overflow.
    function automatic res_t model64(logic [63:0] x, logic [63:0] y,
                                     logic c);
        res_t r;
        logic signed [65:0] s;
        r.d  = x - y - 64'(c);
        r.bo = ({1'b0, x} < ({1'b0, y} + 65'(c)));
        s    = 66'($signed(x)) - 66'($signed(y)) - 66'(c);
        r.of = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF)
             || (s < -66'sh0_8000_0000_0000_0000);
        r.zf = (r.d == 64'd0);
        r.sf = r.d[63];
        return r;
    endfunction

    function automatic res_t model8(logic [7:0] x, logic [7:0] y, logic c);
        res_t r;
        int u;
        int s;
        u    = int'(x) - int'(y) - int'(c);
        s    = int'($signed(x)) - int'($signed(y)) - int'(c);
        r.d  = 64'(u & 255);
        r.bo = (u < 0);
        r.of = (s > 127) || (s < -128);
        r.zf = (r.d == 64'd0);
        r.sf = r.d[7];
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_res(string tag, res_t e);
        chk({tag, " diff"}, diff, e.d);
        chk({tag, " borrow_out"}, 64'(bo), 64'(e.bo));
        chk({tag, " zf"}, 64'(zf), 64'(e.zf));
        chk({tag, " sf"}, 64'(sf), 64'(e.sf));
        chk({tag, " of"}, 64'(of), 64'(e.of));
    endtask

    // Issue one op on the 64-bit DUT; returns at posedge+1 in DONE.
    task automatic issue(logic [63:0] x, logic [63:0] y, logic c,
                         output int lat);
        @(negedge clk);
        a        = x;
        b        = y;
        bin      = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_op(int i, logic [7:0] x, logic [7:0] y, logic c,
                            int exp_lat);
        res_t e;
        int   lat;
        e = model8(x, y, c);
        @(negedge clk);
        s_a           = x;
        s_b           = y;
        s_bin         = c;
        s_in_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid[i] = 1'b0;
        lat = 0;
        while (!s_out_valid[i] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("sweep%0d lat", i), 64'(lat), 64'(exp_lat));
        chk($sformatf("sweep%0d diff", i), 64'(s_diff[i]), e.d);
        chk($sformatf("sweep%0d bo", i), 64'(s_bo[i]), 64'(e.bo));
        chk($sformatf("sweep%0d flags", i),
            64'({s_zf[i], s_sf[i], s_of[i]}), 64'({e.zf, e.sf, e.of}));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[7];
    int   lat;
    res_t e;
    res_t held;
    int   sweep_lat[3];

    initial begin
        nvec        = 0;
        nerr        = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        bin         = 1'b0;
        s_in_valid  = '0;
        s_out_ready = 1'b1;
        s_a         = '0;
        s_b         = '0;
        s_bin       = 1'b0;

        tbl[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'd0, 64'd1, 1'b0, '1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{64'd0, 64'd0, 1'b1, '1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, '1, 1'b0,
                   64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{'1, '1, 1'b1, '1, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);
        chk("post-reset diff", diff, 64'd0);

        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].bin, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd8);
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd0);
            e = '{tbl[i].d, tbl[i].bo, tbl[i].zf, tbl[i].sf, tbl[i].of};
            check_res($sformatf("vec%0d", i), e);
            drain();
            chk($sformatf("vec%0d idle", i), 64'(in_ready), 64'd1);
        end

        // Asynchronous reset mid-cycle while a nonzero result is held.
        issue(64'd0, 64'd1, 1'b0, lat);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        chk("async rst diff", diff, 64'd0);
        chk("async rst flags", 64'({bo, zf, sf, of}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release idle", 64'(in_ready), 64'd1);
        chk("release out_valid", 64'(out_valid), 64'd0);

        // Back-pressure: DONE must hold with in_valid asserted.
        out_ready = 1'b0;
        issue(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 1'b1, lat);
        held = model64(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF,
                       1'b1);
        chk("bp latency", 64'(lat), 64'd8);
        a        = 64'd77;
        b        = 64'd11;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'd0);
            check_res($sformatf("bp%0d", k), held);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        chk("bp drained", 64'(out_valid), 64'd0);
        check_res("idle hold", held);

        // Reset during RUN aborts the op.
        @(negedge clk);
        a        = 64'd9;
        b        = 64'd4;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("run rst out_valid", 64'(out_valid), 64'd0);
        chk("run rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("aborted op stays idle", 64'(out_valid), 64'd0);
        chk("aborted diff", diff, 64'd0);

        // Random ops against the arithmetic model.
        for (int n = 0; n < 200; n++) begin
            logic [63:0] x;
            logic [63:0] y;
            logic        c;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            c = 1'($urandom_range(1));
            if (n % 8 == 0) y = x;
            if (n % 8 == 1) y = x + 64'd1;
            issue(x, y, c, lat);
            chk($sformatf("rnd%0d latency", n), 64'(lat), 64'd8);
            check_res($sformatf("rnd%0d", n), model64(x, y, c));
            drain();
        end

        // WIDTH=8 sweep over CHUNK=1,4,8.
        sweep_lat[0] = 8;
        sweep_lat[1] = 2;
        sweep_lat[2] = 1;
        for (int i = 0; i < 3; i++) begin
            sweep_op(i, 8'h00, 8'h00, 1'b1, sweep_lat[i]);
            sweep_op(i, 8'h80, 8'h01, 1'b0, sweep_lat[i]);
            sweep_op(i, 8'h7F, 8'hFF, 1'b0, sweep_lat[i]);
            sweep_op(i, 8'hFF, 8'hFF, 1'b1, sweep_lat[i]);
            for (int n = 0; n < 1200; n++) begin
                sweep_op(i, 8'($urandom), 8'($urandom),
                         1'($urandom_range(1)), sweep_lat[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
